wr_side_level_ctrl: RTL and testbench

- Write-domain pointer and occupancy controller for the async FIFO; the parametrised successor of the combinational write-count block.
- Owns the write pointer in binary and Gray form.
- Synchronises the raw read Gray pointer through a configurable flop chain, converts it to binary, and produces registered fill count, full, almost-full, sticky overflow and high-watermark.
- Sits beside the RAM write port; its Gray write pointer goes to the read-side synchroniser.

---
 rtl/wr_side_level_ctrl.sv | 58 +++++
 tb/tb_wr_side_level_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wr_side_level_ctrl.sv
// wr_side_level_ctrl: write-domain pointer, read-pointer synchroniser and fill/flag generation for an async FIFO
module wr_side_level_ctrl #(
   parameter int PTR_WIDTH   = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 wr_clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [PTR_WIDTH:0]   rptr_gray_async_i,
   input  logic [PTR_WIDTH:0]   af_thresh_i,
   input  logic                 ovf_clr_i,
   input  logic                 wm_clr_i,
   output logic                 wr_push_o,
   output logic [PTR_WIDTH-1:0] waddr_o,
   output logic [PTR_WIDTH:0]   wptr_bin_o,
   output logic [PTR_WIDTH:0]   wptr_gray_o,
   output logic [PTR_WIDTH:0]   wr_cnt_o,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic                 ovf_o,
   output logic [PTR_WIDTH:0]   wm_o
);
   localparam int W = PTR_WIDTH + 1;
   logic [W-1:0] sync [SYNC_STAGES];
   logic [W-1:0] rg_s, rbin, wbin_n, wgray_n, cnt_n;
   assign rg_s = sync[SYNC_STAGES-1];
   for (genvar g = 0; g < W; g++) begin : g_g2b
      assign rbin[g] = ^(rg_s >> g);
   end
   assign wr_push_o = wr_en_i & ~full_o;
   assign waddr_o   = wptr_bin_o[PTR_WIDTH-1:0];
   assign wbin_n    = wptr_bin_o + W'(wr_push_o);
   assign wgray_n   = wbin_n ^ (wbin_n >> 1);
   assign cnt_n     = wbin_n - rbin;
   always_ff @(posedge wr_clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
         wptr_bin_o    <= '0;
         wptr_gray_o   <= '0;
         wr_cnt_o      <= '0;
         full_o        <= 1'b0;
         almost_full_o <= 1'b0;
         ovf_o         <= 1'b0;
         wm_o          <= '0;
      end else begin
         sync[0] <= rptr_gray_async_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         wptr_bin_o    <= wbin_n;
         wptr_gray_o   <= wgray_n;
         wr_cnt_o      <= cnt_n;
         full_o        <= wgray_n == {~rg_s[W-1:W-2], rg_s[W-3:0]};
         almost_full_o <= (af_thresh_i != '0) && (cnt_n >= af_thresh_i);
         // a blocked write outranks a same-cycle clear so no overflow is lost
         ovf_o         <= (wr_en_i & full_o) | (ovf_o & ~ovf_clr_i);
         wm_o          <= (wm_clr_i || cnt_n > wm_o) ? cnt_n : wm_o;
      end
   end
endmodule

// File: tb/tb_wr_side_level_ctrl.sv
// tb_wr_side_level_ctrl: directed checks of fill, drain latency, wrap, almost-full, clears and async reset
module tb_wr_side_level_ctrl;
   logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, ovf_clr = 1'b0, wm_clr = 1'b0;
   logic [5:0] rptr = '0, af_thresh = '0;
   logic       wr_push, full, almost_full, ovf;
   logic [4:0] waddr;
   logic [5:0] wptr_bin, wptr_gray, wr_cnt, wm;
   int         passed = 0, total = 0;

   wr_side_level_ctrl #(.PTR_WIDTH(5), .SYNC_STAGES(2)) dut (
      .wr_clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .rptr_gray_async_i(rptr),
      .af_thresh_i(af_thresh), .ovf_clr_i(ovf_clr), .wm_clr_i(wm_clr),
      .wr_push_o(wr_push), .waddr_o(waddr), .wptr_bin_o(wptr_bin), .wptr_gray_o(wptr_gray),
      .wr_cnt_o(wr_cnt), .full_o(full), .almost_full_o(almost_full), .ovf_o(ovf), .wm_o(wm)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] gray(input logic [5:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wptr"}, {26'd0, wptr_bin}, 0);
      chk({tag, "_gray"}, {26'd0, wptr_gray}, 0);
      chk({tag, "_cnt"}, {26'd0, wr_cnt}, 0);
      chk({tag, "_flags"}, {28'd0, full, almost_full, ovf, wr_push}, 0);
      chk({tag, "_wm"}, {26'd0, wm}, 0);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 chk_zero("reset");
      tick();
      rst = 1'b0;
      // fill from empty with the read pointer at 0
      wr_en = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk("fill_cnt", {26'd0, wr_cnt}, k);
         chk("fill_full", {31'd0, full}, (k == 32) ? 1 : 0);
      end
      chk("full_push", {31'd0, wr_push}, 0);
      tick();
      chk("ovf_wptr", {26'd0, wptr_bin}, 32'h20);
      chk("ovf_set", {31'd0, ovf}, 1);
      chk("wm_full", {26'd0, wm}, 32);
      chk("af_disabled", {31'd0, almost_full}, 0);
      wr_en = 1'b0;
      ovf_clr = 1'b1;
      tick();
      chk("ovf_clr", {31'd0, ovf}, 0);
      wr_en = 1'b1;
      tick();
      chk("ovf_set_wins", {31'd0, ovf}, 1);
      chk("ovf_hold_wptr", {26'd0, wptr_bin}, 32'h20);
      wr_en = 1'b0;
      ovf_clr = 1'b0;
      // drain visibility: read side reports binary 8
      rptr = 6'h0C;
      tick();
      chk("drain_e1", {25'd0, full, wr_cnt}, {25'd0, 1'b1, 6'd32});
      tick();
      chk("drain_e2", {25'd0, full, wr_cnt}, {25'd0, 1'b1, 6'd32});
      tick();
      chk("drain_e3", {25'd0, full, wr_cnt}, {25'd0, 1'b0, 6'd24});
      // almost-full at 28
      af_thresh = 6'd28;
      wr_en = 1'b1;
      for (int k = 25; k <= 28; k++) begin
         tick();
         chk("af_cnt", {26'd0, wr_cnt}, k);
         chk("af_rise", {31'd0, almost_full}, (k == 28) ? 1 : 0);
      end
      wr_en = 1'b0;
      rptr = gray(6'd9);
      tick();
      chk("af_hold1", {31'd0, almost_full}, 1);
      tick();
      chk("af_hold2", {31'd0, almost_full}, 1);
      tick();
      chk("af_fall", {25'd0, almost_full, wr_cnt}, {25'd0, 1'b0, 6'd27});
      af_thresh = 6'd0;
      // watermark reload at level 10
      rptr = gray(6'd26);
      repeat (3) tick();
      chk("wm_lvl", {26'd0, wr_cnt}, 10);
      chk("wm_before", {26'd0, wm}, 32);
      wm_clr = 1'b1;
      tick();
      chk("wm_clr", {26'd0, wm}, 10);
      wm_clr = 1'b0;
      tick();
      chk("wm_after", {26'd0, wm}, 10);
      // climb to 17 then reset between edges
      wr_en = 1'b1;
      repeat (7) tick();
      wr_en = 1'b0;
      chk("pre_rst_cnt", {26'd0, wr_cnt}, 17);
      rst = 1'b1;
      #1 chk_zero("mid_rst");
      rptr = '0;
      tick();
      rst = 1'b0;
      wr_en = 1'b1;
      tick();
      chk("post_rst_cnt", {26'd0, wr_cnt}, 1);
      repeat (29) tick();
      chk("wrap_c30", {26'd0, wr_cnt}, 30);
      wr_en = 1'b0;
      rptr = gray(6'd20);
      repeat (3) tick();
      chk("wrap_r20", {26'd0, wr_cnt}, 10);
      wr_en = 1'b1;
      repeat (20) tick();
      wr_en = 1'b0;
      chk("wrap_w50", {26'd0, wptr_bin}, 50);
      rptr = gray(6'd40);
      repeat (3) tick();
      chk("wrap_r40", {26'd0, wr_cnt}, 10);
      wr_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("wrap_cnt", {26'd0, wr_cnt}, 10 + k);
         chk("wrap_wptr", {26'd0, wptr_bin}, (50 + k) % 64);
      end
      wr_en = 1'b0;
      chk("wrap_gray", {26'd0, wptr_gray}, {26'd0, gray(6'd6)});
      chk("wrap_waddr", {27'd0, waddr}, 6);
      rptr = 6'h00;
      repeat (3) tick();
      chk("wrap_final_cnt", {26'd0, wr_cnt}, 6);
      chk("wrap_final_wptr", {26'd0, wptr_bin}, 6);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
